// File: rtl/tx_pkg.sv
// TX framer shared types and constants.
// Preamble pattern, state encoding and counter widths.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    GAP
  } tx_state_t;

  localparam logic [12:0] BARKER13 = 13'b1111100110101;
  localparam int PRE_SYMS = 26;
  // 10 bits so 4*255 payload symbols still fit
  localparam int SYM_W = 10;
  localparam int SMP_W = 4;

  function automatic logic barker_bit(
    input logic [SYM_W-1:0] sym
  );
    logic [SYM_W-1:0] k;
    k = (sym < SYM_W'(13)) ? sym : sym - SYM_W'(13);
    return BARKER13[4'(SYM_W'(12) - k)];
  endfunction

endpackage

// File: rtl/tx_sym_map.sv
// Symbol mapper: preamble bit or QPSK dibit to (I,Q).
// Zero request forces (0,0) for stuffing and gaps.
module tx_sym_map #(
  parameter logic signed [15:0] AMP = 16'sh2000
) (
  input  logic               pre,
  input  logic               pre_bit,
  input  logic [1:0]         dibit,
  input  logic               zero,
  output logic signed [15:0] i,
  output logic signed [15:0] q
);

  localparam logic signed [15:0] NEG = -AMP;

  always_comb begin
    i = '0;
    q = '0;
    if (!zero) begin
      if (pre) begin
        i = pre_bit ? AMP : NEG;
        q = pre_bit ? AMP : NEG;
      end else begin
        i = dibit[1] ? NEG : AMP;
        q = dibit[0] ? NEG : AMP;
      end
    end
  end

endmodule

// File: rtl/tx_framer.sv
// Strobe-paced packet framer: Barker preamble, QPSK payload,
// zero gap, zero-stuffed upsampling to the DAC path.
module tx_framer
  import tx_pkg::*;
#(
  parameter int                 PKT_BYTES = 32,
  parameter int                 SPS       = 4,
  parameter logic signed [15:0] AMP       = 16'sh2000,
  parameter int                 GAP_SYMS  = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_en,
  input  logic               i_dac_stb,
  input  logic [7:0]         i_data,
  input  logic               i_data_vld,
  output logic               o_data_rdy,
  output logic signed [15:0] o_datatx_i,
  output logic signed [15:0] o_datatx_q,
  output logic               o_datatx_vld,
  output logic               o_sop,
  output logic               o_eop,
  output logic               o_busy,
  output logic               o_underrun
);

  localparam int PAY_SYMS = 4 * PKT_BYTES;
  localparam logic [SYM_W-1:0] PRE_LAST = SYM_W'(PRE_SYMS - 1);
  localparam logic [SYM_W-1:0] PAY_LAST = SYM_W'(PAY_SYMS - 1);
  localparam logic [SYM_W-1:0] GAP_LAST = SYM_W'(GAP_SYMS - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SPS - 1);
  localparam logic [7:0]       NBYTES   = 8'(PKT_BYTES);

  tx_state_t         state;
  tx_state_t         cur;
  logic [SYM_W-1:0]  sym;
  logic [SMP_W-1:0]  smp;
  logic [7:0]        hold;
  logic [7:0]        shreg;
  logic [7:0]        acc_cnt;
  logic              hold_full;
  logic              ufl;
  logic              start;
  logic              first;
  logic              last_smp;
  logic              bnd;
  logic              load;
  logic              under;
  logic              accept;
  logic [1:0]        dibit;
  logic              zero;
  logic signed [15:0] map_i;
  logic signed [15:0] map_q;

  // a starting strobe is already the first preamble sample
  always_comb begin
    start    = (state == IDLE) && i_en && i_data_vld;
    cur      = start ? PREAMBLE : state;
    first    = (smp == '0);
    last_smp = (smp == SMP_LAST);
    bnd      = (cur == PAYLOAD) && first && (sym[1:0] == 2'b00);
    load     = bnd && hold_full;
    under    = bnd && !hold_full;
    dibit    = bnd ? hold[7:6] : shreg[7:6];
    zero     = !first || under || (cur == IDLE) || (cur == GAP);
  end

  assign o_data_rdy = ((state == PREAMBLE) || (state == PAYLOAD))
                   && !hold_full && (acc_cnt < NBYTES);
  assign accept = i_data_vld && o_data_rdy;
  assign o_busy = (state != IDLE);

  tx_sym_map #(
    .AMP(AMP)
  ) u_map (
    .pre    (cur == PREAMBLE),
    .pre_bit(barker_bit(sym)),
    .dibit  (dibit),
    .zero   (zero),
    .i      (map_i),
    .q      (map_q)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      sym          <= '0;
      smp          <= '0;
      hold         <= '0;
      shreg        <= '0;
      acc_cnt      <= '0;
      hold_full    <= 1'b0;
      ufl          <= 1'b0;
      o_datatx_i   <= '0;
      o_datatx_q   <= '0;
      o_datatx_vld <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_datatx_vld <= i_dac_stb;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_underrun   <= 1'b0;
      if (accept) begin
        hold      <= i_data;
        hold_full <= 1'b1;
        acc_cnt   <= acc_cnt + 8'd1;
      end else if (i_dac_stb && load) begin
        hold_full <= 1'b0;
      end
      if (state == IDLE) begin
        acc_cnt   <= '0;
        hold_full <= 1'b0;
      end
      if (i_dac_stb) begin
        o_datatx_i <= map_i;
        o_datatx_q <= map_q;
        o_sop      <= (cur == PREAMBLE) && (sym == '0) && first;
        o_eop      <= (cur == PAYLOAD) && (sym == PAY_LAST)
                   && last_smp && !ufl;
        o_underrun <= under;
        state      <= cur;
        smp        <= (last_smp || cur == IDLE) ? '0 : smp + 1'b1;
        if (cur == PAYLOAD) begin
          if (load)
            shreg <= {hold[5:0], 2'b00};
          else if (first && sym[1:0] != 2'b00)
            shreg <= {shreg[5:0], 2'b00};
          if (under)
            ufl <= 1'b1;
        end
        if (last_smp) begin
          unique case (cur)
            PREAMBLE: begin
              if (sym == PRE_LAST) begin
                state <= PAYLOAD;
                sym   <= '0;
              end else begin
                sym <= sym + 1'b1;
              end
            end
            PAYLOAD: begin
              // an underrun symbol repeats the same symbol slot
              if (ufl) begin
                ufl <= 1'b0;
              end else if (sym == PAY_LAST) begin
                state <= (GAP_SYMS == 0) ? IDLE : GAP;
                sym   <= '0;
              end else begin
                sym <= sym + 1'b1;
              end
            end
            GAP: begin
              if (sym == GAP_LAST) begin
                state <= IDLE;
                sym   <= '0;
              end else begin
                sym <= sym + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// Bench for tx_framer: packet-level reference model with
// per-cycle compare, plus literal checks on directed packets.
module tb_tx_framer;

  localparam int P    = 3;
  localparam int SPS  = 4;
  localparam int GAP  = 5;
  localparam int NPAY = 4 * P;
  localparam int TOT  = 26 + NPAY + GAP;
  localparam logic [15:0] AP = 16'h2000;
  localparam logic [15:0] AN = 16'hE000;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        sop;
    logic        eop;
    logic        und;
  } smp_t;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_en = 1'b0;
  logic        i_dac_stb = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_data_vld = 1'b0;
  logic        o_data_rdy;
  logic signed [15:0] o_datatx_i;
  logic signed [15:0] o_datatx_q;
  logic        o_datatx_vld;
  logic        o_sop;
  logic        o_eop;
  logic        o_busy;
  logic        o_underrun;

  always #5 i_clk = ~i_clk;

  tx_framer #(
    .PKT_BYTES(P),
    .SPS      (SPS),
    .AMP      (16'sh2000),
    .GAP_SYMS (GAP)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_en        (i_en),
    .i_dac_stb   (i_dac_stb),
    .i_data      (i_data),
    .i_data_vld  (i_data_vld),
    .o_data_rdy  (o_data_rdy),
    .o_datatx_i  (o_datatx_i),
    .o_datatx_q  (o_datatx_q),
    .o_datatx_vld(o_datatx_vld),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_busy      (o_busy),
    .o_underrun  (o_underrun)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [12:0] bark_v = 13'b1111100110101;
  bit          m_act, m_uh, m_rdy;
  int          m_pos, m_sub, m_acc;
  logic [7:0]  m_cur;
  logic [7:0]  mq[$];
  logic [15:0] e_i, e_q;
  bit          e_vld, e_sop, e_eop, e_und;

  // stimulus state
  logic [7:0]  tbl[8] = '{8'hB4, 8'h1E, 8'h63, 8'h5A,
                          8'hC3, 8'h0F, 8'h99, 8'h3C};
  logic [7:0]  dbyte;
  bit          hs, rmode, logging;
  int          n_acc;
  smp_t        log_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_uh = 0; m_rdy = 0;
    m_pos = 0; m_sub = 0; m_acc = 0;
    m_cur = '0;
    mq.delete();
    e_i = '0; e_q = '0;
    e_vld = 0; e_sop = 0; e_eop = 0; e_und = 0;
  endtask

  task automatic model_step();
    bit         acc_now;
    logic [7:0] acc_b;
    logic [7:0] t;
    int         k;
    acc_now = i_data_vld && m_rdy;
    acc_b = i_data;
    e_vld = 0; e_sop = 0; e_eop = 0; e_und = 0;
    if (i_dac_stb) begin
      e_vld = 1; e_i = '0; e_q = '0;
      if (!m_act && i_en && i_data_vld) begin
        m_act = 1; m_pos = 0; m_sub = 0; m_acc = 0; m_uh = 0;
      end
      if (m_act) begin
        if (m_pos < 26) begin
          if (m_sub == 0) begin
            e_i = bark_v[12 - (m_pos % 13)] ? AP : AN;
            e_q = e_i;
            e_sop = (m_pos == 0);
          end
        end else if (m_pos < 26 + NPAY) begin
          k = m_pos - 26;
          if (m_sub == 0) begin
            if (k % 4 == 0) begin
              if (mq.size() == 0) begin
                m_uh = 1;
                e_und = 1;
              end else begin
                m_cur = mq.pop_front();
              end
            end
            if (!m_uh) begin
              t = m_cur >> (6 - 2 * (k % 4));
              e_i = t[1] ? AN : AP;
              e_q = t[0] ? AN : AP;
            end
          end
          e_eop = (k == NPAY - 1) && (m_sub == SPS - 1);
        end
        m_sub++;
        if (m_sub == SPS) begin
          m_sub = 0;
          if (m_uh) m_uh = 0;
          else m_pos++;
        end
        if (m_pos == TOT) m_act = 0;
      end
    end
    if (acc_now) begin
      mq.push_back(acc_b);
      m_acc++;
    end
    m_rdy = m_act && (m_pos < 26 + NPAY) && (mq.size() == 0)
         && (m_acc < P);
  endtask

  task automatic tick(input bit stb, input bit en, input bit vld);
    @(negedge i_clk);
    if (hs) begin
      n_acc++;
      dbyte = rmode ? 8'($urandom) : tbl[n_acc % 8];
    end
    i_dac_stb = stb;
    i_en = en;
    i_data_vld = vld;
    i_data = dbyte;
    hs = vld && o_data_rdy && i_rstn;
  endtask

  function automatic smp_t at(int k);
    smp_t z;
    z = '0;
    if (k >= 0 && k < log_q.size()) return log_q[k];
    return z;
  endfunction

  function automatic int find_sop(int from);
    for (int k = from; k < log_q.size(); k++)
      if (log_q[k].sop) return k;
    return -1;
  endfunction

  function automatic logic [37:0] outs();
    return {o_data_rdy, o_busy, o_datatx_vld, o_datatx_i,
            o_datatx_q, o_sop, o_eop, o_underrun};
  endfunction

  task automatic start_log();
    repeat (3) tick(0, 0, 0);
    log_q.delete();
    n_acc = 0;
    dbyte = tbl[0];
    hs = 0;
    logging = 1;
  endtask

  task automatic do_reset(int n);
    @(negedge i_clk);
    #2 i_rstn = 1'b0;
    hs = 0;
    repeat (n) tick(i_dac_stb, 0, 1);
    hs = 0;
    i_rstn = 1'b1;
  endtask

  initial begin
    logic [25:0] pre_sgn;
    int s0, s1, nbad, ne, nz, nund, lu;
    smp_t sv;
    pre_sgn = 26'b11111001101011111100110101;
    model_reset();
    dbyte = tbl[0];
    hs = 0; rmode = 0; logging = 0; n_acc = 0;
    fork
      begin : stim
        repeat (3) tick(0, 0, 0);
        chk("reset_outputs", 64'(outs()), 64'd0);
        i_rstn = 1'b1;
        repeat (12) tick(1, 0, 1);
        repeat (4) tick(1, 1, 0);
        chk("idle_not_busy", 64'(o_busy), 64'd0);

        // two back-to-back packets, strobe every cycle
        start_log();
        repeat (2 * TOT * SPS) tick(1, 1, 1);
        repeat (6) tick(1, 0, 1);
        logging = 0;
        s0 = find_sop(0);
        chk("first_sop_index", 64'(s0), 64'd0);
        nbad = 0;
        for (int j = 0; j < 26 * SPS; j++) begin
          sv = at(s0 + j);
          if (j % SPS == 0) begin
            if (sv.i !== (pre_sgn[25 - j / SPS] ? AP : AN) ||
                sv.q !== sv.i) nbad++;
          end else if (sv.i !== 16'h0 || sv.q !== 16'h0) begin
            nbad++;
          end
        end
        chk("preamble_pattern", 64'(nbad), 64'd0);
        sv = at(s0 + 104);
        chk("pay_sym0", 64'({sv.i, sv.q}), 64'({AN, AP}));
        sv = at(s0 + 108);
        chk("pay_sym1", 64'({sv.i, sv.q}), 64'({AN, AN}));
        sv = at(s0 + 112);
        chk("pay_sym2", 64'({sv.i, sv.q}), 64'({AP, AN}));
        sv = at(s0 + 116);
        chk("pay_sym3", 64'({sv.i, sv.q}), 64'({AP, AP}));
        sv = at(s0 + 151);
        chk("eop_position", 64'(sv.eop), 64'd1);
        ne = 0;
        foreach (log_q[k]) if (log_q[k].eop) ne++;
        chk("eop_count", 64'(ne), 64'd2);
        s1 = find_sop(s0 + 1);
        chk("gap_zero_samples", 64'(s1 - s0 - 152), 64'd20);
        nz = 0;
        for (int k = s0 + 152; k < s1; k++)
          if (at(k).i !== 16'h0 || at(k).q !== 16'h0) nz++;
        chk("gap_all_zero", 64'(nz), 64'd0);
        chk("bytes_accepted_2pkt", 64'(n_acc), 64'd6);

        // underrun: second byte withheld, strobe every 2 cycles
        start_log();
        tick(1, 1, 1);
        for (int c = 0; c < 1500 && (c < 4 || o_busy); c++)
          tick(c % 2 == 1, 0, (n_acc != 1) || (c >= 300));
        repeat (4) tick(0, 0, 0);
        logging = 0;
        chk("underrun_pkt_done", 64'(o_busy), 64'd0);
        nund = 0; nz = 0; ne = 0; lu = -1;
        foreach (log_q[k]) begin
          if (log_q[k].und) begin nund++; lu = k; end
          if (log_q[k].i !== 16'h0) nz++;
          if (log_q[k].eop) ne++;
        end
        chk("underrun_seen", 64'(nund != 0), 64'd1);
        chk("nonzero_symbols", 64'(nz), 64'(26 + NPAY));
        chk("underrun_eop_count", 64'(ne), 64'd1);
        chk("underrun_bytes", 64'(n_acc), 64'd3);
        sv = at(lu + SPS);
        chk("resume_dibit", 64'({sv.i, sv.q}), 64'({AP, AP}));

        // reset mid-payload
        repeat (2) tick(0, 0, 0);
        tick(1, 1, 1);
        repeat (130) tick(1, 0, 1);
        chk("midpayload_busy", 64'(o_busy), 64'd1);
        @(negedge i_clk);
        #2 i_rstn = 1'b0;
        #1 chk("reset_async", 64'(outs()), 64'd0);
        hs = 0;
        repeat (3) tick(1, 0, 1);
        hs = 0;
        tick(0, 0, 0);
        i_rstn = 1'b1;
        tick(1, 0, 0);
        tick(0, 0, 0);
        chk("post_reset_sample",
            64'({o_datatx_vld, o_busy, o_datatx_i, o_datatx_q}),
            64'({1'b1, 1'b0, 32'h0}));

        // randomized traffic
        rmode = 1;
        begin
          int per;
          per = 4;
          for (int c = 0; c < 9000; c++) begin
            if (c % 600 == 0) per = $urandom_range(1, 5);
            if ($urandom % 3000 == 0) do_reset(2);
            tick((c % per) == 0, ($urandom % 4) != 0,
                 ($urandom % 4) != 0);
          end
        end
        repeat (5) tick(0, 0, 0);
      end
      forever begin
        @(posedge i_clk or negedge i_rstn);
        if (!i_rstn) model_reset();
        else model_step();
      end
      forever begin
        @(negedge i_clk);
        if (logging && o_datatx_vld)
          log_q.push_back('{o_datatx_i, o_datatx_q,
                            o_sop, o_eop, o_underrun});
        chk("cycle",
            64'({o_data_rdy, o_busy, o_datatx_vld, o_datatx_i,
                 o_datatx_q, o_sop, o_eop, o_underrun}),
            64'({m_rdy, m_act, e_vld, e_i, e_q,
                 e_sop, e_eop, e_und}));
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
